// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types for the MEM stage: FSM states, MEM/WB entry.
// Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int C_TIMEOUT_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // One MEM/WB pipeline entry as presented to the writeback stage.
    typedef struct packed {
        logic        syscall;
        logic        regwrite;
        logic        memtoreg;
        logic        align_err;
        logic        bus_err;
        logic [31:0] readdata;
        logic [31:0] aluout;
        logic [31:0] instr;
        logic [4:0]  writereg;
    } memwb_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Data-bus handshake between the MEM stage and data memory.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface
`default_nettype wire

// File: rtl/mem_stage_reg_w.sv
`default_nettype none
// ============================================================================
// Module      : reg_w
// Description : MEM/WB pipeline register with load and bubble controls.
// Revision    : 1.0  initial release
// ============================================================================
module reg_w
    import mips_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   load,
    input  wire logic   bubble,
    input  wire memwb_t d,
    output memwb_t      q
);

    memwb_t r_q;

    // A bubble only clears the control bits; data fields keep stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (bubble) begin
            r_q.syscall   <= 1'b0;
            r_q.regwrite  <= 1'b0;
            r_q.memtoreg  <= 1'b0;
            r_q.align_err <= 1'b0;
            r_q.bus_err   <= 1'b0;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS MEM stage: data-bus access FSM with alignment check,
//               bus timeout and MEM/WB output register.
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        syscall_m,
    input  wire logic        regwrite_m,
    input  wire logic        memtoreg_m,
    input  wire logic        memwrite_m,
    input  wire logic [31:0] aluout_m,
    input  wire logic [31:0] writedata_m,
    input  wire logic [4:0]  writereg_m,
    input  wire logic [31:0] instr_m,
    output logic             stall_m,
    mem_stage_if.master      bus,
    output logic             syscall_w,
    output logic             regwrite_w,
    output logic             memtoreg_w,
    output logic [31:0]      readdata_w,
    output logic [31:0]      aluout_w,
    output logic [31:0]      instr_w,
    output logic [4:0]       writereg_w,
    output logic             align_err_w,
    output logic             bus_err_w
);

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_access;
    logic        w_aligned;
    logic        w_timeout;
    logic        w_issue;
    logic        w_finish;
    logic        w_stall;
    logic        w_load;
    logic        w_bubble;
    memwb_t      w_entry;
    memwb_t      w_q;

    assign w_access  = memwrite_m | memtoreg_m;
    assign w_aligned = (aluout_m[1:0] == 2'b00);
    assign w_timeout = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_issue           = 1'b0;
        w_finish          = 1'b0;
        w_stall           = 1'b0;
        w_load            = 1'b0;
        w_bubble          = 1'b0;
        w_entry           = '0;
        w_entry.syscall   = syscall_m;
        w_entry.regwrite  = regwrite_m;
        w_entry.memtoreg  = memtoreg_m;
        w_entry.aluout    = aluout_m;
        w_entry.instr     = instr_m;
        w_entry.writereg  = writereg_m;

        case (r_state)
            IDLE: begin
                if (w_access && w_aligned) begin
                    w_issue      = 1'b1;
                    w_stall      = 1'b1;
                    w_bubble     = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = WAIT;
                end else begin
                    w_load = 1'b1;
                    // Misaligned access retires without touching the bus.
                    if (w_access) begin
                        w_entry.regwrite  = 1'b0;
                        w_entry.memtoreg  = 1'b0;
                        w_entry.align_err = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Ack takes priority over a timeout in the same cycle.
                if (bus.mem_ack) begin
                    w_finish         = 1'b1;
                    w_load           = 1'b1;
                    w_entry.readdata = memtoreg_m ? bus.mem_rdata : 32'h0;
                    w_cnt_next       = '0;
                    w_state_next     = IDLE;
                end else if (w_timeout) begin
                    w_finish         = 1'b1;
                    w_load           = 1'b1;
                    w_entry.regwrite = 1'b0;
                    w_entry.memtoreg = 1'b0;
                    w_entry.bus_err  = 1'b1;
                    w_cnt_next       = '0;
                    w_state_next     = IDLE;
                end else begin
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= memwrite_m;
            r_mem_addr  <= aluout_m;
            r_mem_wdata <= writedata_m;
        end else if (w_finish) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    // Hazard unit must see no freeze while the stage is held in reset.
    assign stall_m = rst_n & w_stall;

    reg_w u_reg_w (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .bubble (w_bubble),
        .d      (w_entry),
        .q      (w_q)
    );

    assign syscall_w   = w_q.syscall;
    assign regwrite_w  = w_q.regwrite;
    assign memtoreg_w  = w_q.memtoreg;
    assign readdata_w  = w_q.readdata;
    assign aluout_w    = w_q.aluout;
    assign instr_w     = w_q.instr;
    assign writereg_w  = w_q.writereg;
    assign align_err_w = w_q.align_err;
    assign bus_err_w   = w_q.bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage with a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        syscall_m, regwrite_m, memtoreg_m, memwrite_m;
    logic [31:0] aluout_m, writedata_m, instr_m;
    logic [4:0]  writereg_m;
    logic        stall_m;
    logic        syscall_w, regwrite_w, memtoreg_w, align_err_w, bus_err_w;
    logic [31:0] readdata_w, aluout_w, instr_w;
    logic [4:0]  writereg_w;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .syscall_m   (syscall_m),
        .regwrite_m  (regwrite_m),
        .memtoreg_m  (memtoreg_m),
        .memwrite_m  (memwrite_m),
        .aluout_m    (aluout_m),
        .writedata_m (writedata_m),
        .writereg_m  (writereg_m),
        .instr_m     (instr_m),
        .stall_m     (stall_m),
        .bus         (bus),
        .syscall_w   (syscall_w),
        .regwrite_w  (regwrite_w),
        .memtoreg_w  (memtoreg_w),
        .readdata_w  (readdata_w),
        .aluout_w    (aluout_w),
        .instr_w     (instr_w),
        .writereg_w  (writereg_w),
        .align_err_w (align_err_w),
        .bus_err_w   (bus_err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem   [16];

    typedef struct {
        int          lat, stall_cyc, req_cyc;
        logic        we, bus_stable, bubble_ok, req_after;
        logic [31:0] addr, wdata;
        logic        sys, rw, m2r, aerr, berr;
        logic [31:0] rd, alu, ins;
        logic [4:0]  wr;
    } obs_t;

    typedef struct {
        int          lat, stall_cyc, req_cyc;
        logic        we, chk_rd;
        logic [31:0] addr, wdata;
        logic        sys, rw, m2r, aerr, berr;
        logic [31:0] rd, alu, ins;
        logic [4:0]  wr;
    } exp_t;

    obs_t o;
    exp_t e;

    task automatic drive(input logic sys, input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] wr, input logic [31:0] ins);
        syscall_m   = sys;
        regwrite_m  = rw;
        memtoreg_m  = m2r;
        memwrite_m  = mw;
        aluout_m    = addr;
        writedata_m = wdata;
        writereg_m  = wr;
        instr_m     = ins;
    endtask

    // Expected outcome of one instruction whose ack comes dly cycles after
    // mem_req rises (dly >= TO means the memory never answers).
    function automatic void model(input int dly);
        logic access, aligned;
        access  = memwrite_m | memtoreg_m;
        aligned = (aluout_m % 4) == 0;
        e.sys = syscall_m; e.rw = regwrite_m; e.m2r = memtoreg_m;
        e.alu = aluout_m; e.ins = instr_m; e.wr = writereg_m;
        e.aerr = 1'b0; e.berr = 1'b0; e.rd = 32'h0; e.chk_rd = 1'b1;
        e.addr = aluout_m; e.wdata = writedata_m; e.we = memwrite_m;
        if (!access) begin
            e.lat = 1; e.stall_cyc = 0; e.req_cyc = 0;
        end else if (!aligned) begin
            e.lat = 1; e.stall_cyc = 0; e.req_cyc = 0;
            e.rw = 1'b0; e.m2r = 1'b0; e.aerr = 1'b1; e.chk_rd = 1'b0;
        end else if (dly < TO) begin
            e.lat = dly + 2; e.stall_cyc = dly + 1; e.req_cyc = dly + 1;
            if (memtoreg_m) e.rd = ref_mem[(aluout_m / 4) % 16];
            if (memwrite_m) ref_mem[(aluout_m / 4) % 16] = writedata_m;
        end else begin
            e.lat = TO + 1; e.stall_cyc = TO; e.req_cyc = TO;
            e.rw = 1'b0; e.m2r = 1'b0; e.berr = 1'b1; e.chk_rd = 1'b0;
        end
    endfunction

    // Acts as hazard unit and memory slave until the instruction retires.
    task automatic run(input int dly);
        logic done;
        o.lat = -1; o.stall_cyc = 0; o.req_cyc = 0;
        o.we = 1'b0; o.addr = 32'h0; o.wdata = 32'h0;
        o.bus_stable = 1'b1; o.bubble_ok = 1'b1;
        for (int k = 0; k < 64; k++) begin
            bus.mem_ack   = bus.mem_req && (k - 1 == dly);
            bus.mem_rdata = bus.mem_req ? slave_mem[bus.mem_addr[5:2]] : $urandom;
            #1;
            if (stall_m) o.stall_cyc++;
            if (bus.mem_req) begin
                if (o.req_cyc == 0) begin
                    o.addr = bus.mem_addr; o.we = bus.mem_we; o.wdata = bus.mem_wdata;
                end else if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} != {o.addr, o.we, o.wdata}) begin
                    o.bus_stable = 1'b0;
                end
                o.req_cyc++;
            end
            if (k >= 1 && (regwrite_w || memtoreg_w || syscall_w || align_err_w || bus_err_w))
                o.bubble_ok = 1'b0;
            if (bus.mem_ack && bus.mem_we) slave_mem[bus.mem_addr[5:2]] = bus.mem_wdata;
            done = !stall_m;
            @(posedge clk); #1;
            if (done) begin
                o.lat = k + 1;
                break;
            end
        end
        bus.mem_ack = 1'b0;
        o.sys = syscall_w; o.rw = regwrite_w; o.m2r = memtoreg_w;
        o.aerr = align_err_w; o.berr = bus_err_w;
        o.rd = readdata_w; o.alu = aluout_w; o.ins = instr_w; o.wr = writereg_w;
        o.req_after = bus.mem_req;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (stall_m !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_m); else n_pass++;
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 66'h0) $display("FAIL reset_bus: req=%b addr=%h want all 0", bus.mem_req, bus.mem_addr); else n_pass++;
        n_checks++; if ({syscall_w, regwrite_w, memtoreg_w, align_err_w, bus_err_w} !== 5'h0) $display("FAIL reset_ctrl_w: got %b want 00000", {syscall_w, regwrite_w, memtoreg_w, align_err_w, bus_err_w}); else n_pass++;
        n_checks++; if ({readdata_w, aluout_w, instr_w, writereg_w} !== 101'h0) $display("FAIL reset_data_w: aluout=%h readdata=%h want 0", aluout_w, readdata_w); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, $urandom, 5'd5, $urandom);
        model(0); run(0);
        n_checks++; if (o.lat !== e.lat) $display("FAIL alu_latency: got %0d want %0d", o.lat, e.lat); else n_pass++;
        n_checks++; if (o.stall_cyc !== 0) $display("FAIL alu_stall: got %0d cycles want 0", o.stall_cyc); else n_pass++;
        n_checks++; if ({o.alu, o.wr, o.rw} !== {e.alu, e.wr, e.rw}) $display("FAIL alu_entry: aluout=%h wr=%0d rw=%b want %h %0d %b", o.alu, o.wr, o.rw, e.alu, e.wr, e.rw); else n_pass++;
    endtask

    task automatic test_load();
        slave_mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd9, $urandom);
        model(3); run(3);
        n_checks++; if (o.stall_cyc !== e.stall_cyc) $display("FAIL load_stall: got %0d want %0d", o.stall_cyc, e.stall_cyc); else n_pass++;
        n_checks++; if (o.rd !== e.rd) $display("FAIL load_data: got %h want %h", o.rd, e.rd); else n_pass++;
        n_checks++; if ({o.m2r, o.rw, o.wr} !== {e.m2r, e.rw, e.wr}) $display("FAIL load_ctrl: m2r=%b rw=%b wr=%0d want %b %b %0d", o.m2r, o.rw, o.wr, e.m2r, e.rw, e.wr); else n_pass++;
        n_checks++; if ({o.addr, o.we, o.bus_stable} !== {e.addr, e.we, 1'b1}) $display("FAIL load_bus: addr=%h we=%b stable=%b want %h %b 1", o.addr, o.we, o.bus_stable, e.addr, e.we); else n_pass++;
        n_checks++; if (o.bubble_ok !== 1'b1) $display("FAIL load_bubble: got %b want 1", o.bubble_ok); else n_pass++;
    endtask

    task automatic test_store();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFE, 5'd0, $urandom);
        model(0); run(0);
        n_checks++; if ({o.we, o.addr, o.wdata} !== {1'b1, 32'h200, 32'hCAFE}) $display("FAIL store_bus: we=%b addr=%h wdata=%h want 1 00000200 0000cafe", o.we, o.addr, o.wdata); else n_pass++;
        n_checks++; if (o.req_cyc !== e.req_cyc) $display("FAIL store_req_cycles: got %0d want %0d", o.req_cyc, e.req_cyc); else n_pass++;
        n_checks++; if (o.lat !== e.lat) $display("FAIL store_latency: got %0d want %0d", o.lat, e.lat); else n_pass++;
        n_checks++; if (o.req_after !== 1'b0) $display("FAIL store_req_drop: got %b want 0", o.req_after); else n_pass++;
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd4, $urandom);
        model(0); run(0);
        n_checks++; if (o.req_cyc !== 0) $display("FAIL misalign_req: got %0d cycles want 0", o.req_cyc); else n_pass++;
        n_checks++; if ({o.aerr, o.rw, o.m2r, o.sys} !== {e.aerr, e.rw, e.m2r, e.sys}) $display("FAIL misalign_entry: aerr=%b rw=%b m2r=%b sys=%b want %b %b %b %b", o.aerr, o.rw, o.m2r, o.sys, e.aerr, e.rw, e.m2r, e.sys); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 5'd2, $urandom);
        model(0); run(0);
        n_checks++; if (o.aerr !== 1'b0) $display("FAIL misalign_one_cycle: align_err_w=%b want 0", o.aerr); else n_pass++;
    endtask

    task automatic test_timeout();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 5'd6, $urandom);
        model(TO + 10); run(TO + 10);
        n_checks++; if (o.req_cyc !== e.req_cyc) $display("FAIL timeout_req_cycles: got %0d want %0d", o.req_cyc, e.req_cyc); else n_pass++;
        n_checks++; if ({o.berr, o.rw, o.m2r} !== {e.berr, e.rw, e.m2r}) $display("FAIL timeout_entry: berr=%b rw=%b m2r=%b want %b %b %b", o.berr, o.rw, o.m2r, e.berr, e.rw, e.m2r); else n_pass++;
        n_checks++; if (o.lat !== e.lat || o.stall_cyc !== e.stall_cyc) $display("FAIL timeout_timing: lat=%0d stall=%0d want %0d %0d", o.lat, o.stall_cyc, e.lat, e.stall_cyc); else n_pass++;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0, 5'd7, $urandom);
        model(TO - 1); run(TO - 1);
        n_checks++; if ({o.berr, o.m2r, o.rd} !== {1'b0, e.m2r, e.rd}) $display("FAIL ack_at_timeout: berr=%b m2r=%b rd=%h want 0 %b %h", o.berr, o.m2r, o.rd, e.m2r, e.rd); else n_pass++;
        n_checks++; if (o.lat !== e.lat) $display("FAIL ack_at_timeout_latency: got %0d want %0d", o.lat, e.lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0, 5'd8, $urandom);
        model(1); run(1);
        n_checks++; if (o.lat !== e.lat || o.rd !== e.rd) $display("FAIL b2b_first: lat=%0d rd=%h want %0d %h", o.lat, o.rd, e.lat, e.rd); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C, 32'h5A5A, 5'd0, $urandom);
        model(0); run(0);
        n_checks++; if (o.lat !== e.lat || o.req_cyc !== e.req_cyc) $display("FAIL b2b_second: lat=%0d req=%0d want %0d %0d", o.lat, o.req_cyc, e.lat, e.req_cyc); else n_pass++;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0, 5'd1, $urandom);
        model(2); run(2);
        n_checks++; if (o.rd !== e.rd) $display("FAIL b2b_readback: got %h want %h", o.rd, e.rd); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd3, 32'h11);
        model(0); run(0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd4, 32'h22);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.mem_req !== 1'b1) $display("FAIL rstwait_pre: mem_req=%b want 1", bus.mem_req); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.mem_req, stall_m, bus.mem_addr} !== 34'h0) $display("FAIL rstwait_bus: req=%b stall=%b addr=%h want 0", bus.mem_req, stall_m, bus.mem_addr); else n_pass++;
        n_checks++; if ({regwrite_w, aluout_w, instr_w, writereg_w} !== 70'h0) $display("FAIL rstwait_w: rw=%b aluout=%h instr=%h want 0", regwrite_w, aluout_w, instr_w); else n_pass++;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd9, 32'h33);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        rst_n = 1'b1;
        #1;
        n_checks++; if ({bus.mem_req, stall_m} !== 2'b00) $display("FAIL late_ack_comb: req=%b stall=%b want 0 0", bus.mem_req, stall_m); else n_pass++;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        n_checks++; if ({aluout_w, readdata_w, regwrite_w, bus.mem_req} !== {32'h55, 32'h0, 1'b1, 1'b0}) $display("FAIL late_ack_entry: aluout=%h rd=%h rw=%b req=%b want 00000055 0 1 0", aluout_w, readdata_w, regwrite_w, bus.mem_req); else n_pass++;
    endtask

    task automatic test_random();
        int          kind, dly;
        logic [31:0] addr;
        logic        rw, m2r, mw;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
            m2r = (kind == 1); mw = (kind == 2);
            rw  = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       dly = TO + 3;
                1:       dly = TO - 1;
                default: dly = int'($urandom_range(0, 4));
            endcase
            drive(1'($urandom_range(0, 1)), rw, m2r, mw, addr, $urandom, 5'($urandom_range(0, 31)), $urandom);
            model(dly); run(dly);
            n_checks++; if (o.lat !== e.lat || o.stall_cyc !== e.stall_cyc || o.req_cyc !== e.req_cyc) $display("FAIL rand%0d_timing: lat=%0d stall=%0d req=%0d want %0d %0d %0d", i, o.lat, o.stall_cyc, o.req_cyc, e.lat, e.stall_cyc, e.req_cyc); else n_pass++;
            n_checks++; if ({o.sys, o.rw, o.m2r, o.aerr, o.berr} !== {e.sys, e.rw, e.m2r, e.aerr, e.berr}) $display("FAIL rand%0d_ctrl: got %b want %b", i, {o.sys, o.rw, o.m2r, o.aerr, o.berr}, {e.sys, e.rw, e.m2r, e.aerr, e.berr}); else n_pass++;
            n_checks++; if ({o.alu, o.ins, o.wr} !== {e.alu, e.ins, e.wr}) $display("FAIL rand%0d_data: alu=%h ins=%h wr=%0d want %h %h %0d", i, o.alu, o.ins, o.wr, e.alu, e.ins, e.wr); else n_pass++;
            if (e.chk_rd) begin
                n_checks++; if (o.rd !== e.rd) $display("FAIL rand%0d_readdata: got %h want %h", i, o.rd, e.rd); else n_pass++;
            end
            if (e.req_cyc > 0) begin
                n_checks++; if ({o.addr, o.we, o.wdata, o.bus_stable} !== {e.addr, e.we, e.wdata, 1'b1}) $display("FAIL rand%0d_bus: addr=%h we=%b wdata=%h stable=%b want %h %b %h 1", i, o.addr, o.we, o.wdata, o.bus_stable, e.addr, e.we, e.wdata); else n_pass++;
                n_checks++; if (o.bubble_ok !== 1'b1 || o.req_after !== 1'b0) $display("FAIL rand%0d_release: bubble_ok=%b req_after=%b want 1 0", i, o.bubble_ok, o.req_after); else n_pass++;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
